// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretcher
// Description : Turns single-cycle request pulses into fixed-length output
//               windows. Each window is followed by a guaranteed low gap.
//               Requests that arrive while a window or gap is active are
//               counted in a saturating queue and served back to back.
// Ports       :
//   Clock     - system clock; all logic runs on the rising edge
//   Reset     - asynchronous, active-high reset
//   Pi        - request pulse; every high cycle is one request
//   Lo        - stretched output level (high during HOLD)
//   Busy      - high whenever the block is not IDLE
//   Pending   - number of queued requests not yet served
//   Overflow  - one-cycle flag: a request was dropped because Pending was full
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int QW          = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Pi,
  output logic          Lo,
  output logic          Busy,
  output logic [QW-1:0] Pending,
  output logic          Overflow
);

  // The counter must reach max(HOLD,GAP)-1. A width of at least one bit is
  // kept so the 1/1 parameter corner still has a legal vector.
  localparam int c_MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CW   = (c_MAXC <= 1) ? 1 : $clog2(c_MAXC);

  localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_CYCLES - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(GAP_CYCLES - 1);
  localparam logic [QW-1:0]   c_PEND_MAX  = {QW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [QW-1:0]   r_pend;
  logic [QW-1:0]   w_pend_nxt;
  logic            r_ovf;
  logic            w_ovf_nxt;
  logic            w_hold_last;
  logic            w_gap_last;

  assign w_hold_last = (r_cnt == c_HOLD_LAST);
  assign w_gap_last  = (r_cnt == c_GAP_LAST);

  // --------------------------------------------------------------------------
  // State, counter and queue registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, counter and queue logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (Pi) begin
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        if (w_hold_last) begin
          w_state_nxt = S_GAP;
        end
        if (Pi) begin
          if (r_pend != c_PEND_MAX) begin
            w_pend_nxt = r_pend + 1'b1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (w_gap_last) begin
          // A request in the last gap cycle starts the next window directly,
          // so it never enters the queue: the net queue change is <= 0 and
          // overflow is impossible here.
          if (Pi || (r_pend != '0)) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
          if (!Pi && (r_pend != '0)) begin
            w_pend_nxt = r_pend - 1'b1;
          end
        end else if (Pi) begin
          if (r_pend != c_PEND_MAX) begin
            w_pend_nxt = r_pend + 1'b1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Every state entry restarts the cycle count.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  assign Lo       = (r_state == S_HOLD);
  assign Busy     = (r_state != S_IDLE);
  assign Pending  = r_pend;
  assign Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretcher
// Description : Self-checking bench for pulse_stretcher. One default-parameter
//               instance and one HOLD=1/GAP=1 instance share clock and reset.
//               Cycle 0 is the first cycle after reset release; inputs are
//               driven and outputs sampled 1 time unit after each rising edge.
//               Expected outputs for cycle c+1 are queued while cycle c's
//               stimulus is driven, and popped when cycle c+1 is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

  logic       Clock;
  logic       Reset;
  logic       Pi;
  logic       Lo;
  logic       Busy;
  logic [2:0] Pending;
  logic       Overflow;

  logic       Pi2;
  logic       Lo2;
  logic       Busy2;
  logic [2:0] Pending2;
  logic       Overflow2;

  int n_checks;
  int n_pass;

  typedef struct {
    logic       lo;
    logic       busy;
    logic [2:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  pulse_stretcher #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .QW(3)) u_dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Pi       (Pi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Pending  (Pending),
    .Overflow (Overflow)
  );

  pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .QW(3)) u_dut_min (
    .Clock    (Clock),
    .Reset    (Reset),
    .Pi       (Pi2),
    .Lo       (Lo2),
    .Busy     (Busy2),
    .Pending  (Pending2),
    .Overflow (Overflow2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic exp_t mk(input logic lo, input logic busy,
                              input int pend, input logic ovf);
    exp_t e;
    e.lo   = lo;
    e.busy = busy;
    e.pend = 3'(pend);
    e.ovf  = ovf;
    return e;
  endfunction

  function automatic logic inr(input int c, input int lo_c, input int hi_c);
    return (c >= lo_c) && (c <= hi_c);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset just released, inputs low.
  task automatic do_reset();
    Pi    = 1'b0;
    Pi2   = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    sb.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({Lo, Busy, Pending, Overflow} !== 6'b0) begin
      $display("FAIL reset got lo=%b busy=%b pend=%0d ovf=%b exp all zero",
               Lo, Busy, Pending, Overflow);
    end else n_pass++;
    n_checks++;
    if ({Lo2, Busy2, Pending2, Overflow2} !== 6'b0) begin
      $display("FAIL reset_min got lo=%b busy=%b pend=%0d ovf=%b exp all zero",
               Lo2, Busy2, Pending2, Overflow2);
    end else n_pass++;
  endtask

  // Single request in cycle 10: window 11-18, busy 11-20.
  task automatic test_isolated();
    exp_t e;
    int   nc;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      Pi = (c == 10);
      if (c > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (Lo !== e.lo || Busy !== e.busy || Pending !== e.pend || Overflow !== e.ovf) begin
          $display("FAIL isolated c=%0d got lo=%b busy=%b pend=%0d ovf=%b exp lo=%b busy=%b pend=%0d ovf=%b",
                   c, Lo, Busy, Pending, Overflow, e.lo, e.busy, e.pend, e.ovf);
        end else n_pass++;
      end
      nc = c + 1;
      sb.push_back(mk(inr(nc, 11, 18), inr(nc, 11, 20), 0, 1'b0));
      tick();
    end
  endtask

  // Requests in 10, 11, 12: windows 11-18, 21-28, 31-38.
  task automatic test_burst();
    exp_t e;
    int   nc;
    int   p;
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      Pi = (c >= 10 && c <= 12);
      if (c > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (Lo !== e.lo || Busy !== e.busy || Pending !== e.pend || Overflow !== e.ovf) begin
          $display("FAIL burst c=%0d got lo=%b busy=%b pend=%0d ovf=%b exp lo=%b busy=%b pend=%0d ovf=%b",
                   c, Lo, Busy, Pending, Overflow, e.lo, e.busy, e.pend, e.ovf);
        end else n_pass++;
      end
      nc = c + 1;
      p  = (nc == 12) ? 1 : inr(nc, 13, 20) ? 2 : inr(nc, 21, 30) ? 1 : 0;
      sb.push_back(mk(inr(nc, 11, 38) && ((nc - 11) % 10 < 8), inr(nc, 11, 40), p, 1'b0));
      tick();
    end
  endtask

  // Requests in every cycle 10-19: queue saturates at 7, two overflows,
  // then eight windows at a 10-cycle period.
  task automatic test_saturation();
    exp_t e;
    int   nc;
    int   p;
    do_reset();
    for (int c = 0; c <= 95; c++) begin
      Pi = (c >= 10 && c <= 19);
      if (c > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (Lo !== e.lo || Busy !== e.busy || Pending !== e.pend || Overflow !== e.ovf) begin
          $display("FAIL saturation c=%0d got lo=%b busy=%b pend=%0d ovf=%b exp lo=%b busy=%b pend=%0d ovf=%b",
                   c, Lo, Busy, Pending, Overflow, e.lo, e.busy, e.pend, e.ovf);
        end else n_pass++;
      end
      nc = c + 1;
      if (nc <= 11)                p = 0;
      else if (nc <= 18)           p = nc - 11;
      else if (nc <= 20)           p = 7;
      else if (nc <= 90)           p = 6 - (nc - 21) / 10;
      else                         p = 0;
      sb.push_back(mk(inr(nc, 11, 88) && ((nc - 11) % 10 < 8), inr(nc, 11, 90), p,
                      (nc == 19) || (nc == 20)));
      tick();
    end
  endtask

  // Second request lands exactly in the last gap cycle.
  task automatic test_back_to_back();
    exp_t e;
    int   nc;
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      Pi = (c == 10) || (c == 20);
      if (c > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (Lo !== e.lo || Busy !== e.busy || Pending !== e.pend || Overflow !== e.ovf) begin
          $display("FAIL back_to_back c=%0d got lo=%b busy=%b pend=%0d ovf=%b exp lo=%b busy=%b pend=%0d ovf=%b",
                   c, Lo, Busy, Pending, Overflow, e.lo, e.busy, e.pend, e.ovf);
        end else n_pass++;
      end
      nc = c + 1;
      sb.push_back(mk(inr(nc, 11, 18) || inr(nc, 21, 28), inr(nc, 11, 30), 0, 1'b0));
      tick();
    end
  endtask

  // Asynchronous reset in the middle of a window with a queued request.
  task automatic test_reset_mid();
    exp_t e;
    int   nc;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      Pi = (c == 10) || (c == 12);
      tick();
    end
    Pi = 1'b0;
    n_checks++;
    if (Lo !== 1'b1 || Pending !== 3'd1) begin
      $display("FAIL reset_mid_pre got lo=%b pend=%0d exp lo=1 pend=1", Lo, Pending);
    end else n_pass++;
    #3;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({Lo, Busy, Pending, Overflow} !== 6'b0) begin
      $display("FAIL reset_mid_async got lo=%b busy=%b pend=%0d ovf=%b exp all zero",
               Lo, Busy, Pending, Overflow);
    end else n_pass++;
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      Pi = (c == 30);
      if (c > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (Lo !== e.lo || Busy !== e.busy || Pending !== e.pend || Overflow !== e.ovf) begin
          $display("FAIL reset_mid_after c=%0d got lo=%b busy=%b pend=%0d ovf=%b exp lo=%b busy=%b pend=%0d ovf=%b",
                   c, Lo, Busy, Pending, Overflow, e.lo, e.busy, e.pend, e.ovf);
        end else n_pass++;
      end
      nc = c + 1;
      sb.push_back(mk(inr(nc, 31, 38), inr(nc, 31, 40), 0, 1'b0));
      tick();
    end
  endtask

  // HOLD=1, GAP=1 with requests in cycles 10-13: Lo in 11, 13, 15, 17.
  task automatic test_min_params();
    exp_t e;
    int   nc;
    int   p;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      Pi2 = (c >= 10 && c <= 13);
      if (c > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (Lo2 !== e.lo || Busy2 !== e.busy || Pending2 !== e.pend || Overflow2 !== e.ovf) begin
          $display("FAIL min_params c=%0d got lo=%b busy=%b pend=%0d ovf=%b exp lo=%b busy=%b pend=%0d ovf=%b",
                   c, Lo2, Busy2, Pending2, Overflow2, e.lo, e.busy, e.pend, e.ovf);
        end else n_pass++;
      end
      nc = c + 1;
      p  = inr(nc, 12, 13) ? 1 : (nc == 14) ? 2 : inr(nc, 15, 16) ? 1 : 0;
      sb.push_back(mk((nc == 11) || (nc == 13) || (nc == 15) || (nc == 17),
                      inr(nc, 11, 18), p, 1'b0));
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset    = 1'b1;
    Pi       = 1'b0;
    Pi2      = 1'b0;
    test_reset();
    test_isolated();
    test_burst();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_min_params();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
